// File: rtl/sequence_detector_mealy_pkg.sv
// Shared definitions for the serial pattern detector: default configuration
// and the elaboration-time helpers that build the prefix-automaton table.
package seq_det_pkg;

  // Default configuration: detect 1101 with overlapping matches.
  localparam int         SEQ_DET_DEFAULT_W       = 4;
  localparam logic [3:0] SEQ_DET_DEFAULT_PATTERN = 4'b1101;

  // Widest pattern the helpers are written for.
  localparam int         SEQ_DET_MAX_W           = 16;

  // Bit idx of the pattern in arrival order (idx 0 is the first bit received,
  // which lives in the MSB of the pattern word).
  function automatic logic seq_pat_bit(logic [15:0] pattern, int width, int idx);
    return pattern[width - 1 - idx];
  endfunction

  // Length of the longest proper border of the pattern: the longest prefix
  // (shorter than the whole pattern) that is also a suffix.
  function automatic int seq_border(logic [15:0] pattern, int width);
    int   best;
    logic same;
    best = 0;
    for (int k = 1; k < width; k++) begin
      same = 1'b1;
      for (int j = 0; j < k; j++) begin
        if (seq_pat_bit(pattern, width, j) != seq_pat_bit(pattern, width, width - k + j)) begin
          same = 1'b0;
        end
      end
      if (same) begin
        best = k;
      end
    end
    return best;
  endfunction

  // Next value of the matched-length counter.
  // The candidate string is the first `matched` pattern bits followed by
  // in_bit.  A completed pattern resumes from the border (overlap) or from
  // empty; otherwise the result is the longest pattern prefix that ends the
  // candidate string.
  function automatic int seq_next_state(logic [15:0] pattern, int width, int matched,
                                        logic in_bit, bit overlap);
    int   cand_len;
    int   best;
    logic same;
    logic cand_bit;
    if ((matched == width - 1) && (in_bit == pattern[0])) begin
      return overlap ? seq_border(pattern, width) : 0;
    end
    cand_len = matched + 1;
    best     = 0;
    for (int k = 1; (k <= cand_len) && (k < width); k++) begin
      same = 1'b1;
      for (int j = 0; j < k; j++) begin
        // Position within the candidate string that lines up with prefix bit j.
        if ((cand_len - k + j) < matched) begin
          cand_bit = seq_pat_bit(pattern, width, cand_len - k + j);
        end else begin
          cand_bit = in_bit;
        end
        if (seq_pat_bit(pattern, width, j) != cand_bit) begin
          same = 1'b0;
        end
      end
      if (same) begin
        best = k;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/sequence_detector_mealy_if.sv
// Serial bit stream into the detector and the Mealy detect flag back out.
interface sequence_detector_mealy_if;
  logic in;   // serial data bit, one per clock
  logic out;  // combinational detect flag

  // Stream source side: drives bits, observes the flag.
  modport master (
    output in,
    input  out
  );

  // Detector side.
  modport slave (
    input  in,
    output out
  );
endinterface

// File: rtl/sequence_detector_mealy.sv
// Parameterizable Mealy serial pattern detector.  A counter holds how many
// pattern bits are already matched; a next-state table derived from the
// pattern at elaboration time (prefix automaton) advances it each clock.
// The detect flag is combinational from the counter and the live input bit.
module sequence_detector_mealy
  import seq_det_pkg::*;
#(
  parameter int                   PATTERN_W = SEQ_DET_DEFAULT_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(SEQ_DET_DEFAULT_PATTERN),
  parameter bit                   OVERLAP   = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,  // synchronous, active-low
  sequence_detector_mealy_if.slave  bus
);

  // Counter width; a 2-bit pattern still needs one bit of state.
  localparam int MW = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  // Every encodable counter value gets a table row so the lookup never
  // leaves the array; rows past PATTERN_W-1 are unreachable and map to 0.
  localparam int NS = 1 << MW;

  localparam logic [MW-1:0] LAST_STATE = MW'(PATTERN_W - 1);

  logic [MW-1:0] r_matched;
  logic [MW-1:0] w_matched_next;
  logic          w_hit;
  logic [MW-1:0] w_next_tbl [NS][2];

  // Next-state table, one entry per (matched, input bit) pair.
  for (genvar gi = 0; gi < NS; gi++) begin : g_state
    for (genvar gj = 0; gj < 2; gj++) begin : g_bit
      if (gi < PATTERN_W) begin : g_live
        localparam int NXT = seq_next_state(16'(PATTERN), PATTERN_W, gi, (gj != 0), OVERLAP);
        assign w_next_tbl[gi][gj] = MW'(NXT);
      end else begin : g_unused
        assign w_next_tbl[gi][gj] = '0;
      end
    end
  end

  // Hit detection and next-state lookup for the current bit.
  always_comb begin
    w_hit          = 1'b0;
    w_matched_next = r_matched;
    w_hit          = (r_matched == LAST_STATE) && (bus.in == PATTERN[0]);
    w_matched_next = w_next_tbl[r_matched][bus.in];
  end

  // Detect flag is forced low while reset is held.
  assign bus.out = w_hit & reset;

  // Matched-length register; reset discards any partial match.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_matched <= '0;
    end else begin
      r_matched <= w_matched_next;
    end
  end

endmodule

// File: tb/tb_sequence_detector_mealy.sv
// Bench for the serial pattern detector.  Three instances share one input
// stream: default 1101 overlapping, 1101 non-overlapping, and 000 (width 3)
// overlapping.  The reference keeps the raw bit history since the last
// restart and flags a hit when that history ends with the pattern.
module tb_sequence_detector_mealy;

  logic clk;
  logic rst_n;
  logic r_din;

  sequence_detector_mealy_if ifa ();
  sequence_detector_mealy_if ifb ();
  sequence_detector_mealy_if ifc ();

  assign ifa.in = r_din;
  assign ifb.in = r_din;
  assign ifc.in = r_din;

  sequence_detector_mealy #(
    .PATTERN_W (4),
    .PATTERN   (4'b1101),
    .OVERLAP   (1'b1)
  ) dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifa)
  );

  sequence_detector_mealy #(
    .PATTERN_W (4),
    .PATTERN   (4'b1101),
    .OVERLAP   (1'b0)
  ) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifb)
  );

  sequence_detector_mealy #(
    .PATTERN_W (3),
    .PATTERN   (3'b000),
    .OVERLAP   (1'b1)
  ) dut_c (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic din;
    logic rst;
    logic ea;
    logic eb;
    logic ec;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   stim_done = 1'b0;

  bit hist_a[$];
  bit hist_b[$];
  bit hist_c[$];

  // True when the bit history ends with the w-bit pattern (MSB first).
  function automatic bit ends_with(bit h[$], logic [15:0] pat, int w);
    if (h.size() < w) return 1'b0;
    for (int i = 0; i < w; i++) begin
      if (h[h.size() - w + i] != pat[w - 1 - i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Drive one bit for one clock cycle and queue the expected flags.
  task automatic drive(input logic b, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    r_din = b;
    rst_n = r;
    e.cyc = cyc;
    e.din = b;
    e.rst = r;
    if (!r) begin
      e.ea = 1'b0;
      e.eb = 1'b0;
      e.ec = 1'b0;
      hist_a.delete();
      hist_b.delete();
      hist_c.delete();
    end else begin
      hist_a.push_back(b);
      hist_b.push_back(b);
      hist_c.push_back(b);
      e.ea = ends_with(hist_a, 16'b1101, 4);
      e.eb = ends_with(hist_b, 16'b1101, 4);
      e.ec = ends_with(hist_c, 16'b000, 3);
      // Non-overlapping detection forgets everything up to and including a hit.
      if (e.eb) hist_b.delete();
      if (hist_a.size() > 16) void'(hist_a.pop_front());
      if (hist_b.size() > 16) void'(hist_b.pop_front());
      if (hist_c.size() > 16) void'(hist_c.pop_front());
    end
    sb_q.push_back(e);
    cyc++;
  endtask

  // Monitor: sample mid-cycle and compare against the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("cyc %0d rst_n=%0b in=%0b out a/b/c=%0b%0b%0b exp=%0b%0b%0b",
                 e.cyc, e.rst, e.din, ifa.out, ifb.out, ifc.out, e.ea, e.eb, e.ec);
        checks++;
        if (ifa.out !== e.ea) begin
          errors++;
          $display("FAIL out_a cyc %0d got %0b want %0b", e.cyc, ifa.out, e.ea);
        end
        checks++;
        if (ifb.out !== e.eb) begin
          errors++;
          $display("FAIL out_b cyc %0d got %0b want %0b", e.cyc, ifb.out, e.eb);
        end
        checks++;
        if (ifc.out !== e.ec) begin
          errors++;
          $display("FAIL out_c cyc %0d got %0b want %0b", e.cyc, ifc.out, e.ec);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog stim_done=%0b got timeout want completion", stim_done);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [15:0] stream;
    logic [4:0]  corner;
    logic        rb;
    r_din = 1'b0;
    rst_n = 1'b0;

    // Reset hold: pattern bits presented while reset is low.
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);

    // Default stream: 1,1,0,1,1,0,1,0,1,1,0,1,0,1,1,0
    stream = 16'b1101_1010_1101_0110;
    for (int i = 15; i >= 0; i--) drive(stream[i], 1'b1);

    // Mid-pattern reset, then a fresh 1101.
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);

    // Prefix-fallback corner: 1,1,1,0,1
    drive(1'b0, 1'b0);
    corner = 5'b11101;
    for (int i = 4; i >= 0; i--) drive(corner[i], 1'b1);

    // Run of zeros for the 000 instance.
    drive(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);

    // Randomized stream with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rb = ($urandom_range(0, 49) != 0);
      drive(1'(($urandom_range(0, 99) < 60) ? 1 : 0), rb);
    end

    stim_done = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_detector_mealy.md
# sequence_detector_mealy

Parameterizable Mealy-type serial bit-pattern detector. Samples one input bit per clock and asserts its output combinationally during the cycle in which the final bit of the configured pattern is present on the input. Default configuration detects `1101` with overlapping matches. Serves as a leaf block fed by any single-bit serial stream in the `clk` domain.

## Interface
- `PATTERN_W`, 4: pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1101: pattern to detect. MSB is the first bit received, LSB the last.
- `OVERLAP`, 1: 1 means matches may share bits (after a hit, tracking resumes from the longest proper prefix that is also a suffix of the pattern); 0 means tracking restarts from empty after a hit.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `in`  in  1  serial data bit, sampled on every rising edge of `clk`.
- `out`  out  1  Mealy detect flag: high while the current `in` completes the pattern.

## Operation
- State register `matched` holds the number of pattern bits already matched, 0..PATTERN_W-1. Width is clog2(PATTERN_W).
- The current `matched` value and `in` together form a candidate string: the first `matched` bits of the pattern, followed by `in`.
- Hit condition: `matched == PATTERN_W-1` and `in` equals the pattern LSB.
- `out` = hit AND `reset` high. It is purely combinational from `matched` and `in`, with no output register.
- Next state, non-hit: the length of the longest prefix of the pattern that is a suffix of the candidate string. This is the standard KMP/prefix-automaton transition and may be 0.
- Next state, hit with OVERLAP=1: the length of the longest proper border of `PATTERN` (1 for `1101`).
- Next state, hit with OVERLAP=0: 0.
- Transition table is computed at elaboration from `PATTERN`. No runtime pattern programming.
- Default automaton (`1101`, OVERLAP=1), written as state/in->next:
  - 0/0->0, 0/1->1
  - 1/0->0, 1/1->2
  - 2/0->3, 2/1->2
  - 3/0->0, 3/1->1 with `out`=1
- Only bit values 0 and 1 are specified. X or Z on `in` is not required to be handled.

## Timing
- When `reset` is low at a rising edge, `matched` becomes 0. `out` is 0 for the whole time `reset` is low, regardless of `in`.
- Reset asserted mid-pattern discards all partial progress. The first bit sampled after release starts from state 0.
- Latency: `out` rises in the same cycle the final pattern bit is driven, before the edge that samples it (zero-cycle Mealy response). It stays high only while that condition holds.
- Back-to-back hits are possible every (PATTERN_W − border) cycles with OVERLAP=1, and every PATTERN_W cycles with OVERLAP=0.
- A glitch on `in` within a cycle may glitch `out`. Consumers sample `out` on `clk`.

## Structure
- Shared package `seq_det_pkg` holds:
  - default constants `SEQ_DET_DEFAULT_W=4` and `SEQ_DET_DEFAULT_PATTERN=4'b1101`;
  - the function `seq_next_state(pattern, width, matched, bit, overlap)` used to build the transition table;
  - the function `seq_border(pattern, width)`.
- No sub-module. A single module contains:
  - a generate-built next-state table;
  - the `matched` register;
  - the combinational `out` logic.

## Test plan
- **Reset hold:** keep `reset` low and drive `in` with 1,1,0,1 -> `out` stays 0 throughout, and `matched` is 0 after release.
- **Default stream, overlap:** drive 1,1,0,1,1,0,1,0,1,1,0,1,0,1,1,0 starting from the first cycle after reset release -> `out` is high exactly in bit cycles 3, 6 and 11 (0-based), low in all others.
- **Non-overlap:** repeat the same stream with OVERLAP=0 -> `out` is high exactly in cycles 3 and 11.
- **Mid-pattern reset:** drive 1,1,0, pull `reset` low for one edge, then drive 1 -> `out` stays 0. Then drive 1,0,1 -> `out` goes high on that final 1.
- **Prefix-fallback corner:** drive 1,1,1,0,1 -> `out` is high only on the last bit, since state stays at 2 through the repeated 1s.
- **Alternate parameters:** with PATTERN_W=3, PATTERN=3'b000, OVERLAP=1, drive 0,0,0,0,0 -> `out` is high in cycles 2, 3 and 4.
